mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  single clock; all state updates on rising edge
  rst_n  in  1  synchronous reset, active-low
  if_req_valid  in  1  fetch request present
  if_req_addr  in  ADDR_W  fetch address
  if_req_ready  out  1  fetch request accepted this cycle
  if_rsp_valid  out  1  fetch response, one-cycle pulse
  if_rsp_data  out  DATA_W  fetch read data
  ls_req_valid  in  1  load/store request present
  ls_req_addr  in  ADDR_W  load/store address
  ls_req_we  in  1  1 = store, 0 = load
  ls_req_wdata  in  DATA_W  store data
  ls_req_be  in  DATA_W/8  store byte enables
  ls_req_ready  out  1  load/store request accepted this cycle
  ls_rsp_valid  out  1  load/store response, one-cycle pulse
  ls_rsp_data  out  DATA_W  load data (store: memory ack data, passed through)
  mem_req_valid  out  1  request to memory
  mem_req_ready  in  1  memory accepts request
  mem_addr, mem_we, mem_wdata, mem_be  out  ADDR_W,1,DATA_W,DATA_W/8  latched request fields
  mem_rsp_valid  in  1  memory response (one per request, loads and stores)
  mem_rsp_data  in  DATA_W  memory response data
  busy  out  1  state != IDLE
  err_stray  out  1  sticky: mem_rsp_valid seen outside WAIT

Function
REQ-003 Block SHALL share one memory port between fetch (IF) and load/store (LS), with at most one outstanding transaction.
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, RSP.
REQ-005 IDLE: if any request is valid, grant one and assert that requester's ready combinationally in the same cycle; latch addr/we/wdata/be and owner; next state REQ. No request: stay IDLE.
REQ-006 Grant rule: only one valid -> grant it; both valid -> LS wins unless starve_cnt == STARVE_MAX, then IF wins.
REQ-007 For IF grants, mem_we SHALL be 0 and mem_be all ones.
REQ-008 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment, saturating at STARVE_MAX, on every IDLE grant to LS while if_req_valid=1; SHALL clear on every IF grant; otherwise hold.
REQ-009 REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready=1 go to WAIT, else stay.
REQ-010 WAIT: on mem_rsp_valid=1 latch mem_rsp_data and go to RSP, else stay; no timeout.
REQ-011 RSP: assert owner's rsp_valid for exactly one cycle with latched data; non-owner rsp_valid stays 0; next state IDLE.
REQ-012 Both *_req_ready SHALL be 0 in REQ, WAIT, RSP; new grants only in IDLE, so back-to-back transactions are 4 cycles apart minimum.
REQ-013 Minimum latency: accept in cycle T, mem_req_valid at T+1, response at T+3 when mem_req_ready=1 at T+1 and mem_rsp_valid=1 at T+2.
REQ-014 mem_rsp_valid in IDLE, REQ or RSP SHALL be ignored (no data capture, no state change) and SHALL set err_stray.
REQ-015 rsp_data outputs SHALL hold last latched value when rsp_valid=0.

Reset
REQ-016 When rst_n=0 at a rising edge: state=IDLE, starve_cnt=0, err_stray=0, owner=IF, latched fields=0, response data=0.
REQ-017 During and after reset all outputs SHALL be 0 until a new grant; reset mid-transaction aborts it with no response pulse to either requester.

Verification
REQ-018 Only LS load addr 0x100, memory ready immediately, data 0xDEADBEEF one cycle later -> ls_req_ready at T, mem_req_valid T+1, ls_rsp_valid with 0xDEADBEEF at T+3, if_rsp_valid stays 0.
REQ-019 IF and LS both continuously valid, STARVE_MAX=4 -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF,...
REQ-020 LS store addr 0x40, wdata 0x12345678, be 0x3, mem_req_ready held low 5 cycles -> mem_req_valid high 6 cycles, fields stable throughout, ls_rsp_valid single pulse after ack.
REQ-021 mem_rsp_valid pulsed while IDLE -> err_stray=1 and stays 1, no rsp_valid, state IDLE; next rst_n=0 clears it.
REQ-022 rst_n driven low in WAIT -> next cycle busy=0, mem_req_valid=0, no rsp_valid; subsequent IF request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with a single
// transaction in flight; load/store has priority, bounded by a fetch starvation limit.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                ls_req_valid,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic                ls_req_we,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_be,
    output logic                ls_req_ready,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rsp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                busy,
    output logic                err_stray
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              grant_if, grant_ls;

    // Fetch only beats a competing load/store once it has lost STARVE_MAX times in a row.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state_q == IDLE) begin
            if (ls_req_valid && !(if_req_valid && (starve_q == STARVE_LIM))) begin
                grant_ls = 1'b1;
            end else if (if_req_valid) begin
                grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        err_d    = err_q || (mem_rsp_valid && (state_q != WAIT));
        case (state_q)
            IDLE: begin
                if (grant_ls) begin
                    state_d = REQ;
                    owner_d = OWNER_LS;
                    addr_d  = ls_req_addr;
                    we_d    = ls_req_we;
                    wdata_d = ls_req_wdata;
                    be_d    = ls_req_be;
                    if (if_req_valid && (starve_q != STARVE_LIM)) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (grant_if) begin
                    state_d  = REQ;
                    owner_d  = OWNER_IF;
                    addr_d   = if_req_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    be_d     = '1;
                    starve_d = '0;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rdata_d = mem_rsp_data;
                    state_d = RSP;
                end
            end
            RSP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWNER_IF;
            starve_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            be_q     <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Handshake outputs are masked while reset is held so nothing is granted or pulsed.
    assign if_req_ready  = rst_n && grant_if;
    assign ls_req_ready  = rst_n && grant_ls;
    assign mem_req_valid = rst_n && (state_q == REQ);
    assign if_rsp_valid  = rst_n && (state_q == RSP) && (owner_q == OWNER_IF);
    assign ls_rsp_valid  = rst_n && (state_q == RSP) && (owner_q == OWNER_LS);
    assign if_rsp_data   = rdata_q;
    assign ls_rsp_data   = rdata_q;
    assign mem_addr      = addr_q;
    assign mem_we        = we_q;
    assign mem_wdata     = wdata_q;
    assign mem_be        = be_q;
    assign busy          = (state_q != IDLE);
    assign err_stray     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester driver, memory model and
// response monitor run as separate processes around a reference model.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;
    localparam int STARVE_MAX = 4;

    logic              clk;
    logic              rst_n;
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;
    logic              ls_req_valid;
    logic [ADDR_W-1:0] ls_req_addr;
    logic              ls_req_we;
    logic [DATA_W-1:0] ls_req_wdata;
    logic [BE_W-1:0]   ls_req_be;
    logic              ls_req_ready;
    logic              ls_rsp_valid;
    logic [DATA_W-1:0] ls_rsp_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              busy;
    logic              err_stray;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .ls_req_valid(ls_req_valid), .ls_req_addr(ls_req_addr), .ls_req_we(ls_req_we),
        .ls_req_wdata(ls_req_wdata), .ls_req_be(ls_req_be), .ls_req_ready(ls_req_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .busy(busy), .err_stray(err_stray)
    );

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mreq_t;

    rsp_t        rsp_q[$];
    mreq_t       req_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dut_mem [logic [31:0]];

    int compared   = 0;
    int mismatched = 0;
    bit outstanding = 0;
    int ref_starve  = 0;
    bit drop_if = 0;
    bit drop_ls = 0;
    int stall_fixed = 0;
    int rsp_fixed   = 0;
    bit stray_req = 0;
    bit mem_flush = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] ack_word(input logic [31:0] a);
        return ~a ^ 32'h00C0_FFEE;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return dut_mem.exists(a) ? dut_mem[a] : init_word(a);
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
        if (drop_if) begin if_req_valid = 1'b0; drop_if = 0; end
        if (drop_ls) begin ls_req_valid = 1'b0; drop_ls = 0; end
    endtask

    // Reference arbitration: one transaction at a time, LS first unless fetch
    // has already lost STARVE_MAX consecutive contested rounds.
    task automatic tick_check();
        logic [1:0] exp;
        mreq_t m;
        rsp_t  r;
        #1;
        exp = 2'b00;
        if (!outstanding) begin
            if (ls_req_valid && if_req_valid) exp = (ref_starve == STARVE_MAX) ? 2'b10 : 2'b01;
            else if (ls_req_valid)            exp = 2'b01;
            else if (if_req_valid)            exp = 2'b10;
        end
        compare("req_ready", 64'({if_req_ready, ls_req_ready}), 64'(exp));
        if (exp == 2'b10) begin
            m = '{addr: if_req_addr, we: 1'b0, wdata: 32'h0, be: 4'hF};
            r = '{owner: 1'b0, data: ref_read(if_req_addr)};
            req_q.push_back(m);
            rsp_q.push_back(r);
            ref_starve  = 0;
            drop_if     = 1;
            outstanding = 1;
        end else if (exp == 2'b01) begin
            m = '{addr: ls_req_addr, we: ls_req_we, wdata: ls_req_wdata, be: ls_req_be};
            if (ls_req_we) begin
                ref_mem[ls_req_addr] = merge(ref_read(ls_req_addr), ls_req_wdata, ls_req_be);
                r = '{owner: 1'b1, data: ack_word(ls_req_addr)};
            end else begin
                r = '{owner: 1'b1, data: ref_read(ls_req_addr)};
            end
            req_q.push_back(m);
            rsp_q.push_back(r);
            if (if_req_valid && ref_starve < STARVE_MAX) ref_starve++;
            drop_ls     = 1;
            outstanding = 1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (outstanding && n < budget) begin
            next_cycle();
            tick_check();
            n++;
        end
        if (outstanding) fail_evt(name);
    endtask

    initial begin : mem_model
        int          stall_left;
        bit          rsp_pending;
        int          rsp_wait;
        logic [31:0] rsp_word;
        mreq_t       h;
        stall_left = -1;
        rsp_pending = 0;
        rsp_wait = 0;
        rsp_word = 0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (mem_flush) begin
                rsp_pending = 0;
                stall_left  = -1;
                mem_flush   = 0;
            end
            if (stray_req) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = $urandom;
                stray_req     = 0;
            end else if (rsp_pending) begin
                if (rsp_wait == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = rsp_word;
                    rsp_pending   = 0;
                end else begin
                    rsp_wait--;
                end
            end
            if (mem_req_valid) begin
                if (req_q.size() == 0) begin
                    fail_evt("mem_req_unexpected");
                end else begin
                    h = req_q[0];
                    compare("mem_addr", 64'(mem_addr), 64'(h.addr));
                    compare("mem_we", 64'(mem_we), 64'(h.we));
                    compare("mem_be", 64'(mem_be), 64'(h.be));
                    if (h.we) compare("mem_wdata", 64'(mem_wdata), 64'(h.wdata));
                    if (stall_left < 0)
                        stall_left = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 3));
                    if (stall_left == 0) begin
                        mem_req_ready = 1'b1;
                        stall_left    = -1;
                        h = req_q.pop_front();
                        rsp_pending = 1;
                        rsp_wait = (rsp_fixed >= 0) ? rsp_fixed : int'($urandom_range(0, 2));
                        if (mem_we) begin
                            dut_mem[mem_addr] = merge(mem_read(mem_addr), mem_wdata, mem_be);
                            rsp_word = ack_word(mem_addr);
                        end else begin
                            rsp_word = mem_read(mem_addr);
                        end
                    end else begin
                        stall_left--;
                    end
                end
            end
        end
    end

    initial begin : monitor
        rsp_t e;
        forever begin
            @(posedge clk);
            #4;
            if (if_rsp_valid || ls_rsp_valid) begin
                if (if_rsp_valid && ls_rsp_valid) begin
                    fail_evt("rsp_both_valid");
                end else if (rsp_q.size() == 0) begin
                    fail_evt("rsp_unexpected");
                end else begin
                    e = rsp_q.pop_front();
                    compare("rsp_owner", 64'(ls_rsp_valid), 64'(e.owner));
                    compare("rsp_data", 64'(ls_rsp_valid ? ls_rsp_data : if_rsp_data), 64'(e.data));
                end
                outstanding = 0;
            end
        end
    end

    initial begin : stimulus
        int cnt_v;
        int cnt_r;
        int ng;
        int cyc;
        bit exp_if[10];
        exp_if = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        rst_n = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h4;
        ls_req_valid = 1'b1; ls_req_addr = 32'h8; ls_req_we = 1'b1;
        ls_req_wdata = 32'hFFFF_FFFF; ls_req_be = 4'hF;

        // Reset holds everything quiet even with both requesters active.
        repeat (3) begin
            @(posedge clk);
            #3;
            compare("reset_ctrl", 64'({busy, mem_req_valid, if_req_ready, ls_req_ready,
                                        if_rsp_valid, ls_rsp_valid, err_stray}), 64'(0));
            compare("reset_fields", 64'({mem_we, mem_be, mem_addr}), 64'(0));
            compare("reset_wdata", 64'(mem_wdata), 64'(0));
            compare("reset_rdata", 64'({if_rsp_data, ls_rsp_data}), 64'(0));
        end
        @(posedge clk);
        #2;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        rst_n = 1'b1;

        // Single load with minimum latency.
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        dut_mem[32'h100] = 32'hDEAD_BEEF;
        stall_fixed = 0;
        rsp_fixed   = 0;
        next_cycle();
        ls_req_valid = 1'b1; ls_req_addr = 32'h100; ls_req_we = 1'b0;
        ls_req_wdata = 32'h0; ls_req_be = 4'h0;
        tick_check();
        compare("lat_t0_memvalid", 64'(mem_req_valid), 64'(0));
        next_cycle();
        compare("lat_t1_memvalid", 64'(mem_req_valid), 64'(1));
        tick_check();
        next_cycle();
        tick_check();
        compare("lat_t2_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'(0));
        next_cycle();
        tick_check();
        compare("lat_t3_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'(2'b01));
        wait_idle("load_timeout", 10);

        // Store with memory stalling for five cycles.
        stall_fixed = 5;
        next_cycle();
        ls_req_valid = 1'b1; ls_req_addr = 32'h40; ls_req_we = 1'b1;
        ls_req_wdata = 32'h1234_5678; ls_req_be = 4'h3;
        tick_check();
        cnt_v = 0;
        cnt_r = 0;
        repeat (12) begin
            next_cycle();
            tick_check();
            if (mem_req_valid) cnt_v++;
            if (ls_rsp_valid) cnt_r++;
        end
        compare("stall_memvalid_cycles", 64'(cnt_v), 64'(6));
        compare("stall_rsp_pulses", 64'(cnt_r), 64'(1));
        wait_idle("store_timeout", 10);
        stall_fixed = 0;

        // Stray memory response while idle.
        next_cycle();
        stray_req = 1;
        tick_check();
        next_cycle();
        tick_check();
        next_cycle();
        tick_check();
        compare("stray_err_set", 64'(err_stray), 64'(1));
        compare("stray_busy", 64'(busy), 64'(0));
        repeat (3) next_cycle();
        compare("stray_err_sticky", 64'(err_stray), 64'(1));
        rst_n = 1'b0;
        next_cycle();
        compare("stray_err_cleared", 64'(err_stray), 64'(0));
        compare("reset_rdata_cleared", 64'({if_rsp_data, ls_rsp_data}), 64'(0));
        rst_n = 1'b1;
        ref_starve = 0;

        // Reset while waiting for the memory response.
        rsp_fixed = 4;
        next_cycle();
        if_req_valid = 1'b1; if_req_addr = 32'h8;
        tick_check();
        next_cycle();
        tick_check();
        next_cycle();
        compare("wait_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        mem_flush = 1;
        next_cycle();
        #1;
        compare("abort_ctrl", 64'({busy, mem_req_valid, if_rsp_valid, ls_rsp_valid}), 64'(0));
        compare("abort_addr", 64'(mem_addr), 64'(0));
        rst_n = 1'b1;
        rsp_q.delete();
        req_q.delete();
        outstanding = 0;
        ref_starve  = 0;
        repeat (6) begin
            next_cycle();
            tick_check();
        end
        rsp_fixed = 0;
        next_cycle();
        if_req_valid = 1'b1; if_req_addr = 32'hC;
        tick_check();
        wait_idle("post_abort_timeout", 10);

        // Both requesters continuously valid: fetch wins every fifth grant.
        ng  = 0;
        cyc = 0;
        if_req_addr = 32'h20;
        ls_req_addr = 32'h24; ls_req_we = 1'b0; ls_req_be = 4'h0; ls_req_wdata = 32'h0;
        while (ng < 10 && cyc < 100) begin
            next_cycle();
            if_req_valid = 1'b1;
            ls_req_valid = 1'b1;
            tick_check();
            if (if_req_ready || ls_req_ready) begin
                compare($sformatf("grant_order_%0d", ng), 64'(if_req_ready), 64'(exp_if[ng]));
                ng++;
            end
            cyc++;
        end
        if (ng < 10) fail_evt("grant_order_timeout");
        next_cycle();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        tick_check();
        wait_idle("order_drain_timeout", 10);

        // Randomized traffic with random memory stalls and response delays.
        stall_fixed = -1;
        rsp_fixed   = -1;
        for (int c = 0; c < 1500; c++) begin
            next_cycle();
            if (!if_req_valid && $urandom_range(0, 2) == 0) begin
                if_req_valid = 1'b1;
                if_req_addr  = 32'($urandom_range(0, 7)) << 2;
            end
            if (!ls_req_valid && $urandom_range(0, 2) == 0) begin
                ls_req_valid = 1'b1;
                ls_req_addr  = 32'($urandom_range(0, 7)) << 2;
                ls_req_we    = 1'($urandom_range(0, 1));
                ls_req_wdata = $urandom;
                ls_req_be    = 4'($urandom_range(0, 15));
            end
            tick_check();
        end
        next_cycle();
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        tick_check();
        wait_idle("random_drain_timeout", 50);
        compare("scoreboard_rsp_empty", 64'(rsp_q.size()), 64'(0));
        compare("scoreboard_req_empty", 64'(req_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
